// File: rtl/llm_mm_arb_pkg.sv
// Shared types and helpers for the llm_mm_arbiter matmul-core sharing slice.
package llm_mm_arb_pkg;

  typedef logic owner_t;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  localparam int unsigned MAX_OUTSTANDING_DFLT = 4;

  // Pointer width for a power-of-two tag FIFO; one bit minimum.
  function automatic int unsigned tag_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned TAG_PTR_W = tag_ptr_w(MAX_OUTSTANDING_DFLT);

endpackage

// File: rtl/llm_mm_arbiter_if.sv
// Bus bundle between the two requesters, the shared matmul core and the
// arbiter. slave: arbiter side. master: environment (requesters/core) side.
interface llm_mm_arbiter_if #(
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned IN_SIZE        = 4,
  parameter int unsigned IN_PARALLELISM = 20,
  parameter int unsigned OUT_WIDTH      = 32,
  parameter int unsigned OUT_ROWS       = 20,
  parameter int unsigned OUT_COLUMNS    = 1
);
  localparam int unsigned IN_ELEMS  = IN_PARALLELISM * IN_SIZE;
  localparam int unsigned OUT_ELEMS = OUT_ROWS * OUT_COLUMNS;

  logic [IN_ELEMS-1:0][IN_WIDTH-1:0]   req0_data;
  logic [IN_ELEMS-1:0][IN_WIDTH-1:0]   req1_data;
  logic                                req0_valid;
  logic                                req1_valid;
  logic                                req0_ready;
  logic                                req1_ready;
  logic [IN_ELEMS-1:0][IN_WIDTH-1:0]   core_data;
  logic                                core_valid;
  logic                                core_ready;
  logic                                core_sel;
  logic [OUT_ELEMS-1:0][OUT_WIDTH-1:0] core_result;
  logic                                core_result_valid;
  logic                                core_result_ready;
  logic [OUT_ELEMS-1:0][OUT_WIDTH-1:0] resp0_data;
  logic [OUT_ELEMS-1:0][OUT_WIDTH-1:0] resp1_data;
  logic                                resp0_valid;
  logic                                resp1_valid;
  logic                                resp0_ready;
  logic                                resp1_ready;

  modport slave (
    input  req0_data, req1_data, req0_valid, req1_valid,
    output req0_ready, req1_ready,
    output core_data, core_valid, core_sel,
    input  core_ready,
    input  core_result, core_result_valid,
    output core_result_ready,
    output resp0_data, resp1_data, resp0_valid, resp1_valid,
    input  resp0_ready, resp1_ready
  );

  modport master (
    output req0_data, req1_data, req0_valid, req1_valid,
    input  req0_ready, req1_ready,
    input  core_data, core_valid, core_sel,
    output core_ready,
    output core_result, core_result_valid,
    input  core_result_ready,
    input  resp0_data, resp1_data, resp0_valid, resp1_valid,
    output resp0_ready, resp1_ready
  );

endinterface

// File: rtl/llm_mm_tag_fifo.sv
// Synchronous owner-tag FIFO; push and pop in one cycle are both honoured.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module llm_mm_tag_fifo
  import llm_mm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DFLT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_t din,
  input  logic   pop,
  output owner_t head,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PTR_W = tag_ptr_w(DEPTH);

  owner_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Tag storage; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/llm_mm_arbiter.sv
// Shares one matmul core between two requesters. A grant lasts a full
// IN_DEPTH-beat transaction; owner tags queue up so each core result goes
// back to the requester that issued it.
// Optional: define LLM_MM_ARB_STRICT_PRIO_EN for fixed priority to requester 0
// (default build is round-robin).
module llm_mm_arbiter
  import llm_mm_arb_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 16,
  parameter int unsigned IN_SIZE         = 4,
  parameter int unsigned IN_PARALLELISM  = 20,
  parameter int unsigned OUT_WIDTH       = 32,
  parameter int unsigned OUT_ROWS        = 20,
  parameter int unsigned OUT_COLUMNS     = 1,
  parameter int unsigned IN_DEPTH        = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  llm_mm_arbiter_if.slave         bus,
  output logic                    err
);
  localparam int unsigned CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  arb_state_t       state;
  owner_t           owner;
  owner_t           winner;
  logic [CNT_W-1:0] beat_cnt;
  logic             in_burst;
  logic             beat_hs;
  logic             last_beat;
  logic             tag_push;
  logic             tag_pop;
  owner_t           head_tag;
  logic             fifo_full;
  logic             fifo_empty;

  logic [IN_PARALLELISM*IN_SIZE-1:0][IN_WIDTH-1:0] beat_mux;
  logic [OUT_ROWS*OUT_COLUMNS-1:0][OUT_WIDTH-1:0]  result_bus;

`ifndef LLM_MM_ARB_STRICT_PRIO_EN
  owner_t rr_ptr;
`endif

  // Winner selection for a new grant.
  always_comb begin
    winner = 1'b0;
`ifdef LLM_MM_ARB_STRICT_PRIO_EN
    winner = bus.req0_valid ? 1'b0 : 1'b1;
`else
    if (bus.req0_valid && bus.req1_valid) winner = rr_ptr;
    else                                  winner = bus.req0_valid ? 1'b0 : 1'b1;
`endif
  end

  assign in_burst  = (state == BURST);
  assign beat_mux  = owner ? bus.req1_data : bus.req0_data;
  assign beat_hs   = bus.core_valid && bus.core_ready;
  assign last_beat = (beat_cnt == CNT_W'(IN_DEPTH - 1));
  assign tag_push  = beat_hs && last_beat;

  assign bus.core_data  = beat_mux;
  assign bus.core_valid = in_burst && (owner ? bus.req1_valid : bus.req0_valid);
  assign bus.core_sel   = owner;
  assign bus.req0_ready = in_burst && (owner == 1'b0) && bus.core_ready;
  assign bus.req1_ready = in_burst && (owner == 1'b1) && bus.core_ready;

  // Grant FSM: IDLE picks an owner, BURST counts beats until the transaction ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
`ifndef LLM_MM_ARB_STRICT_PRIO_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_full && (bus.req0_valid || bus.req1_valid)) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat_hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
`ifndef LLM_MM_ARB_STRICT_PRIO_EN
              rr_ptr   <= !owner;
`endif
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  llm_mm_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (owner),
    .pop   (tag_pop),
    .head  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Result routing follows the oldest outstanding tag.
  assign result_bus             = bus.core_result;
  assign bus.resp0_data         = result_bus;
  assign bus.resp1_data         = result_bus;
  assign bus.resp0_valid        = bus.core_result_valid && !fifo_empty && (head_tag == 1'b0);
  assign bus.resp1_valid        = bus.core_result_valid && !fifo_empty && (head_tag == 1'b1);
  assign bus.core_result_ready  = !fifo_empty && (head_tag ? bus.resp1_ready : bus.resp0_ready);
  assign tag_pop                = bus.core_result_valid && bus.core_result_ready;

  // Sticky error for a result arriving with no outstanding tag.
  always_ff @(posedge clk) begin
    if (rst)                                       err <= 1'b0;
    else if (bus.core_result_valid && fifo_empty)  err <= 1'b1;
  end

endmodule

// File: tb/tb_llm_mm_arbiter.sv
// Directed self-checking bench for llm_mm_arbiter (default parameters).
module tb_llm_mm_arbiter;
  import llm_mm_arb_pkg::*;

  localparam int unsigned IN_WIDTH        = 16;
  localparam int unsigned IN_SIZE         = 4;
  localparam int unsigned IN_PARALLELISM  = 20;
  localparam int unsigned OUT_WIDTH       = 32;
  localparam int unsigned OUT_ROWS        = 20;
  localparam int unsigned OUT_COLUMNS     = 1;
  localparam int unsigned IN_DEPTH        = 3;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned IN_ELEMS        = IN_PARALLELISM * IN_SIZE;
  localparam int unsigned OUT_ELEMS       = OUT_ROWS * OUT_COLUMNS;

  typedef logic [IN_ELEMS-1:0][IN_WIDTH-1:0]   beat_t;
  typedef logic [OUT_ELEMS-1:0][OUT_WIDTH-1:0] res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  llm_mm_arbiter_if #(
    .IN_WIDTH       (IN_WIDTH),
    .IN_SIZE        (IN_SIZE),
    .IN_PARALLELISM (IN_PARALLELISM),
    .OUT_WIDTH      (OUT_WIDTH),
    .OUT_ROWS       (OUT_ROWS),
    .OUT_COLUMNS    (OUT_COLUMNS)
  ) bus ();

  llm_mm_arbiter #(
    .IN_WIDTH        (IN_WIDTH),
    .IN_SIZE         (IN_SIZE),
    .IN_PARALLELISM  (IN_PARALLELISM),
    .OUT_WIDTH       (OUT_WIDTH),
    .OUT_ROWS        (OUT_ROWS),
    .OUT_COLUMNS     (OUT_COLUMNS),
    .IN_DEPTH        (IN_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  function automatic beat_t mk_beat(input int unsigned r, input int unsigned idx);
    beat_t b;
    for (int unsigned e = 0; e < IN_ELEMS; e++) b[e] = 16'(r * 4096 + idx * 256 + e);
    return b;
  endfunction

  function automatic res_t mk_res(input int unsigned k);
    res_t v;
    for (int unsigned e = 0; e < OUT_ELEMS; e++) v[e] = 32'hA500_0000 + 32'(k * 65536 + e);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data  = '0;   bus.req1_data  = '0;
    bus.core_ready = 1'b0; bus.core_result_valid = 1'b0;
    bus.core_result = '0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.core_ready = 1'b1;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready,
         bus.core_result_ready, bus.resp0_valid, bus.resp1_valid, err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v/sel/r0/r1/crr/rv0/rv1/err=%b%b%b%b%b%b%b%b exp 00000000",
               bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready,
               bus.core_result_ready, bus.resp0_valid, bus.resp1_valid, err);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = mk_beat(0, 0); bus.core_ready = 1'b1;
    #1;
    checks++;
    if ({bus.core_valid, bus.req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got valid/ready=%b%b exp 00", bus.core_valid, bus.req0_ready);
    end
    @(negedge clk);
    for (int unsigned b = 0; b < IN_DEPTH; b++) begin
      bus.req0_data = mk_beat(0, b);
      #1;
      checks++;
      if ({bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready} !== 4'b1010 ||
          bus.core_data !== mk_beat(0, b)) begin
        errors++;
        $display("FAIL single_beat%0d: got v/sel/r0/r1=%b%b%b%b data0=%h exp 1010 data0=%h", b,
                 bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready,
                 bus.core_data[0], 16'(b * 256));
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.core_result = mk_res(0); bus.core_result_valid = 1'b1;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    checks++;
    if ({bus.core_valid, bus.resp0_valid, bus.resp1_valid, bus.core_result_ready} !== 4'b0101 ||
        bus.resp0_data !== mk_res(0)) begin
      errors++;
      $display("FAIL single_result: got cv/rv0/rv1/crr=%b%b%b%b d0=%h exp 0101 d0=%h",
               bus.core_valid, bus.resp0_valid, bus.resp1_valid, bus.core_result_ready,
               bus.resp0_data[0], 32'hA500_0000);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_s;
    do_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.core_ready = 1'b1;
    bus.req0_data = mk_beat(0, 0); bus.req1_data = mk_beat(1, 0);
    for (int unsigned c = 0; c < 4 * (IN_DEPTH + 1); c++) begin
`ifdef LLM_MM_ARB_STRICT_PRIO_EN
      exp_s = 1'b0;
`else
      exp_s = 1'((c / (IN_DEPTH + 1)) % 2);
`endif
      #1;
      checks++;
      if ((c % (IN_DEPTH + 1)) == 0) begin
        if ({bus.core_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
          errors++;
          $display("FAIL rr_idle_c%0d: got v/r0/r1=%b%b%b exp 000", c,
                   bus.core_valid, bus.req0_ready, bus.req1_ready);
        end
      end else if ({bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready} !==
                   {1'b1, exp_s, !exp_s, exp_s} ||
                   bus.core_data !== (exp_s ? mk_beat(1, 0) : mk_beat(0, 0))) begin
        errors++;
        $display("FAIL rr_grant_c%0d: got v/sel/r0/r1=%b%b%b%b exp %b%b%b%b", c,
                 bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready,
                 1'b1, exp_s, !exp_s, exp_s);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef LLM_MM_ARB_STRICT_PRIO_EN
      exp_s = 1'b0;
`else
      exp_s = 1'(k % 2);
`endif
      bus.core_result = mk_res(k); bus.core_result_valid = 1'b1;
      bus.resp0_ready = exp_s; bus.resp1_ready = !exp_s;
      #1;
      checks++;
      if (bus.core_result_ready !== 1'b0) begin
        errors++;
        $display("FAIL rr_wrong_ready_k%0d: got crr=%b exp 0", k, bus.core_result_ready);
      end
      bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
      #1;
      checks++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.core_result_ready} !== {!exp_s, exp_s, 1'b1} ||
          (exp_s ? bus.resp1_data : bus.resp0_data) !== mk_res(k)) begin
        errors++;
        $display("FAIL rr_result_k%0d: got rv0/rv1/crr=%b%b%b exp %b%b1", k,
                 bus.resp0_valid, bus.resp1_valid, bus.core_result_ready, !exp_s, exp_s);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.core_ready = 1'b1;
    repeat (4 * (IN_DEPTH + 1)) @(negedge clk);
    for (int unsigned c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.core_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
        errors++;
        $display("FAIL full_hold_c%0d: got v/r0/r1=%b%b%b exp 000", c,
                 bus.core_valid, bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
    end
    bus.core_result = mk_res(9); bus.core_result_valid = 1'b1; bus.resp0_ready = 1'b1;
    #1;
    checks++;
    if ({bus.core_valid, bus.resp0_valid, bus.core_result_ready} !== 3'b011) begin
      errors++;
      $display("FAIL full_pop: got v/rv0/crr=%b%b%b exp 011",
               bus.core_valid, bus.resp0_valid, bus.core_result_ready);
    end
    @(negedge clk);
    bus.core_result_valid = 1'b0; bus.resp0_ready = 1'b0;
    #1;
    checks++;
    if (bus.core_valid !== 1'b0) begin
      errors++;
      $display("FAIL regrant_idle: got v=%b exp 0", bus.core_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL regrant_burst: got v/sel/r0/r1=%b%b%b%b exp 1010",
               bus.core_valid, bus.core_sel, bus.req0_ready, bus.req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    bus.req0_valid = 1'b1; bus.core_ready = 1'b1; bus.req0_data = mk_beat(0, 0);
    @(negedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({bus.core_valid, bus.core_sel, bus.req1_ready} !== 3'b000) begin
        errors++;
        $display("FAIL stall_c%0d: got v/sel/r1=%b%b%b exp 000", c,
                 bus.core_valid, bus.core_sel, bus.req1_ready);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b1;
    for (int unsigned b = 1; b < IN_DEPTH; b++) begin
      bus.req0_data = mk_beat(0, b);
      #1;
      checks++;
      if ({bus.core_valid, bus.core_sel, bus.req1_ready} !== 3'b100 ||
          bus.core_data !== mk_beat(0, b)) begin
        errors++;
        $display("FAIL resume_beat%0d: got v/sel/r1=%b%b%b data0=%h exp 100 data0=%h", b,
                 bus.core_valid, bus.core_sel, bus.req1_ready, bus.core_data[0], 16'(b * 256));
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if (bus.core_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end_idle: got v=%b exp 0", bus.core_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.core_valid, bus.core_sel, bus.req1_ready} !== 3'b111) begin
      errors++;
      $display("FAIL stall_next_grant: got v/sel/r1=%b%b%b exp 111",
               bus.core_valid, bus.core_sel, bus.req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_stray_and_reset();
    do_reset();
    bus.core_result_valid = 1'b1; bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    checks++;
    if ({bus.core_result_ready, bus.resp0_valid, bus.resp1_valid, err} !== 4'b0000) begin
      errors++;
      $display("FAIL stray_ready: got crr/rv0/rv1/err=%b%b%b%b exp 0000",
               bus.core_result_ready, bus.resp0_valid, bus.resp1_valid, err);
    end
    @(negedge clk);
    bus.core_result_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.core_ready = 1'b1;
    for (int unsigned c = 0; c < 2 * (IN_DEPTH + 1) - 1; c++) begin
      #1;
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky_c%0d: got err=%b exp 1", c, err);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.core_valid, bus.req0_ready, err} !== 3'b000) begin
      errors++;
      $display("FAIL midburst_reset: got v/r0/err=%b%b%b exp 000",
               bus.core_valid, bus.req0_ready, err);
    end
    bus.core_result_valid = 1'b1;
    #1;
    checks++;
    if ({bus.core_result_ready, bus.resp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_fifo_empty: got crr/rv0=%b%b exp 00",
               bus.core_result_ready, bus.resp0_valid);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_stray_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
